if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage_pkg.sv | 21 ++
 rtl/if_stage.sv | 95 +++++++++
 tb/tb_if_stage.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/if_stage_pkg.sv
// Shared widths, encodings and constants for the instruction-fetch stage
// and the pipeline controller that drives it.
package if_stage_pkg;

  localparam int STALL_LEVEL_LEN = 2;
  localparam int JUMP_INFO_LEN   = 2;
  localparam int RAM_ADDR_LEN    = 32;
  localparam int INST_LEN        = 32;

  localparam int JUMP_ID = 0;
  localparam int JUMP_EX = 1;

  localparam logic [STALL_LEVEL_LEN-1:0] STALL_NULL = 2'd0;
  localparam logic [STALL_LEVEL_LEN-1:0] STALL_IF   = 2'd1;
  localparam logic [STALL_LEVEL_LEN-1:0] STALL_ID   = 2'd2;
  localparam logic [STALL_LEVEL_LEN-1:0] STALL_ALL  = 2'd3;

  localparam logic [INST_LEN-1:0] ZERO_WORD = '0;
  localparam logic                ENABLE    = 1'b1;

endpackage

// File: rtl/if_stage.sv
// Instruction fetch stage: issues word fetches at the fetch PC, holds the
// returned word for IF/ID and redirects on ID/EX jumps without leaking stale words.
module if_stage
  import if_stage_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic [STALL_LEVEL_LEN-1:0] stall_command,
  input  logic [JUMP_INFO_LEN-1:0]   jp,
  input  logic [RAM_ADDR_LEN-1:0]    jp_id_target,
  input  logic [RAM_ADDR_LEN-1:0]    jp_ex_target,
  output logic                       mem_req,
  output logic [RAM_ADDR_LEN-1:0]    mem_addr,
  input  logic                       mem_rdy,
  input  logic [INST_LEN-1:0]        mem_data,
  output logic [RAM_ADDR_LEN-1:0]    if_pc,
  output logic [INST_LEN-1:0]        if_inst,
  output logic                       if_stall_req
);

  typedef enum logic [1:0] {IDLE, FETCH, READY, FLUSH} state_t;

  localparam logic [RAM_ADDR_LEN-1:0] PC_STEP = RAM_ADDR_LEN'(4);

  state_t                  state, state_n;
  logic [RAM_ADDR_LEN-1:0] pc, pc_n;
  logic [RAM_ADDR_LEN-1:0] inflight, inflight_n;
  logic [INST_LEN-1:0]     word, word_n;
  logic                    jump;
  logic [RAM_ADDR_LEN-1:0] target;

  assign jump   = (jp[JUMP_EX] == ENABLE) || (jp[JUMP_ID] == ENABLE);
  assign target = (jp[JUMP_EX] == ENABLE) ? jp_ex_target : jp_id_target;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pc       <= ZERO_WORD;
      inflight <= ZERO_WORD;
      word     <= ZERO_WORD;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      inflight <= inflight_n;
      word     <= word_n;
    end
  end

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    inflight_n = inflight;
    word_n     = word;
    if (jump) pc_n = target;
    unique case (state)
      IDLE: begin
        word_n  = ZERO_WORD;
        state_n = FETCH;
      end
      FETCH: begin
        if (jump && !mem_rdy) begin
          // The request at the old PC is still outstanding; keep its address on the bus.
          inflight_n = pc;
          state_n    = FLUSH;
        end else if (jump) begin
          state_n = FETCH;
        end else if (mem_rdy) begin
          word_n  = mem_data;
          state_n = READY;
        end
      end
      READY: begin
        if (jump) begin
          word_n  = ZERO_WORD;
          state_n = FETCH;
        end else if (stall_command == STALL_NULL) begin
          pc_n    = pc + PC_STEP;
          state_n = FETCH;
        end
      end
      FLUSH: begin
        // A response here belongs to the superseded address; drop it and refetch.
        if (mem_rdy) state_n = FETCH;
      end
      default: state_n = IDLE;
    endcase
  end

  assign mem_req      = (state == FETCH) || (state == FLUSH);
  assign mem_addr     = (state == FLUSH) ? inflight : pc;
  assign if_pc        = (state == READY) ? pc : ZERO_WORD;
  assign if_inst      = (state == READY) ? word : ZERO_WORD;
  assign if_stall_req = (state != READY);

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: reset, fetch, stall, flush, jump priority,
// PC wrap and reset during an outstanding fetch.
module tb_if_stage;
  import if_stage_pkg::*;

  logic                       clk = 1'b0;
  logic                       rst;
  logic [STALL_LEVEL_LEN-1:0] stall_command;
  logic [JUMP_INFO_LEN-1:0]   jp;
  logic [RAM_ADDR_LEN-1:0]    jp_id_target;
  logic [RAM_ADDR_LEN-1:0]    jp_ex_target;
  logic                       mem_req;
  logic [RAM_ADDR_LEN-1:0]    mem_addr;
  logic                       mem_rdy;
  logic [INST_LEN-1:0]        mem_data;
  logic [RAM_ADDR_LEN-1:0]    if_pc;
  logic [INST_LEN-1:0]        if_inst;
  logic                       if_stall_req;

  int errors = 0;
  int checks = 0;

  if_stage dut (
    .clk(clk), .rst(rst), .stall_command(stall_command), .jp(jp),
    .jp_id_target(jp_id_target), .jp_ex_target(jp_ex_target),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdy(mem_rdy), .mem_data(mem_data),
    .if_pc(if_pc), .if_inst(if_inst), .if_stall_req(if_stall_req)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall_command = STALL_ALL; jp = '0;
    jp_id_target = '0; jp_ex_target = '0; mem_rdy = 1'b0; mem_data = '0;
    step(); step();
    checks++; if ({mem_req, if_stall_req} !== 2'b01) begin errors++; $display("FAIL reset_ctrl: req/stall=%b want 01", {mem_req, if_stall_req}); end
    checks++; if ({if_pc, if_inst} !== 64'h0) begin errors++; $display("FAIL reset_out: pc=%h inst=%h want 0", if_pc, if_inst); end
    rst = 1'b0;
    step();
    checks++; if ({mem_req, mem_addr} !== {1'b1, 32'h0}) begin errors++; $display("FAIL first_req: req=%b addr=%h want 1/0", mem_req, mem_addr); end
  endtask

  task automatic test_first_fetch();
    step();
    checks++; if ({mem_req, mem_addr} !== {1'b1, 32'h0}) begin errors++; $display("FAIL addr_stable: req=%b addr=%h want 1/0", mem_req, mem_addr); end
    mem_rdy = 1'b1; mem_data = 32'h0000_0013;
    step();
    mem_rdy = 1'b0;
    checks++; if ({if_pc, if_inst} !== {32'h0, 32'h0000_0013}) begin errors++; $display("FAIL first_word: pc=%h inst=%h want 0/00000013", if_pc, if_inst); end
    checks++; if ({mem_req, if_stall_req} !== 2'b00) begin errors++; $display("FAIL ready_ctrl: req/stall=%b want 00", {mem_req, if_stall_req}); end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if ({if_pc, if_inst, if_stall_req} !== {32'h0, 32'h0000_0013, 1'b0}) begin errors++; $display("FAIL stall_hold%0d: pc=%h inst=%h stall=%b", i, if_pc, if_inst, if_stall_req); end
    end
    stall_command = STALL_NULL;
    step();
    checks++; if ({mem_req, mem_addr, if_stall_req} !== {1'b1, 32'h4, 1'b1}) begin errors++; $display("FAIL advance: req=%b addr=%h stall=%b want 1/4/1", mem_req, mem_addr, if_stall_req); end
    checks++; if (if_inst !== 32'h0) begin errors++; $display("FAIL fetch_inst_zero: inst=%h want 0", if_inst); end
    mem_rdy = 1'b1; mem_data = 32'h1111_1111;
    step();
    mem_rdy = 1'b0;
    checks++; if ({if_pc, if_inst} !== {32'h4, 32'h1111_1111}) begin errors++; $display("FAIL second_word: pc=%h inst=%h want 4/11111111", if_pc, if_inst); end
    step();
    checks++; if ({mem_req, mem_addr} !== {1'b1, 32'h8}) begin errors++; $display("FAIL fetch8: req=%b addr=%h want 1/8", mem_req, mem_addr); end
  endtask

  task automatic test_flush();
    jp = 2'b10; jp_ex_target = 32'h100;
    step();
    jp = 2'b00;
    checks++; if ({mem_req, mem_addr, if_stall_req} !== {1'b1, 32'h8, 1'b1}) begin errors++; $display("FAIL flush_addr: req=%b addr=%h stall=%b want 1/8/1", mem_req, mem_addr, if_stall_req); end
    step();
    checks++; if (mem_addr !== 32'h8) begin errors++; $display("FAIL flush_hold: addr=%h want 8", mem_addr); end
    mem_rdy = 1'b1; mem_data = 32'hDEAD_BEEF;
    step();
    mem_rdy = 1'b0;
    checks++; if ({mem_req, mem_addr, if_inst} !== {1'b1, 32'h100, 32'h0}) begin errors++; $display("FAIL flush_redirect: req=%b addr=%h inst=%h want 1/100/0", mem_req, mem_addr, if_inst); end
    stall_command = STALL_ALL;
    mem_rdy = 1'b1; mem_data = 32'h2222_2222;
    step();
    mem_rdy = 1'b0;
    checks++; if ({if_pc, if_inst} !== {32'h100, 32'h2222_2222}) begin errors++; $display("FAIL flush_word: pc=%h inst=%h want 100/22222222", if_pc, if_inst); end
  endtask

  task automatic test_jump_priority();
    stall_command = STALL_NULL;
    step();
    checks++; if (mem_addr !== 32'h104) begin errors++; $display("FAIL fetch104: addr=%h want 104", mem_addr); end
    jp = 2'b11; jp_ex_target = 32'h200; jp_id_target = 32'h300;
    mem_rdy = 1'b1; mem_data = 32'hBADB_AD00;
    step();
    jp = 2'b00; mem_rdy = 1'b0;
    checks++; if ({mem_req, mem_addr, if_inst, if_stall_req} !== {1'b1, 32'h200, 32'h0, 1'b1}) begin errors++; $display("FAIL ex_wins: req=%b addr=%h inst=%h stall=%b", mem_req, mem_addr, if_inst, if_stall_req); end
    stall_command = STALL_ALL;
    mem_rdy = 1'b1; mem_data = 32'h3333_3333;
    step();
    mem_rdy = 1'b0;
    checks++; if ({if_pc, if_inst} !== {32'h200, 32'h3333_3333}) begin errors++; $display("FAIL no_stale: pc=%h inst=%h want 200/33333333", if_pc, if_inst); end
    jp = 2'b01; jp_id_target = 32'h300;
    step();
    jp = 2'b00;
    checks++; if ({mem_req, mem_addr, if_inst} !== {1'b1, 32'h300, 32'h0}) begin errors++; $display("FAIL id_jump_stalled: req=%b addr=%h inst=%h want 1/300/0", mem_req, mem_addr, if_inst); end
  endtask

  task automatic test_wrap();
    jp = 2'b10; jp_ex_target = 32'hFFFF_FFFC;
    mem_rdy = 1'b1; mem_data = 32'hBADB_AD01;
    step();
    jp = 2'b00; mem_rdy = 1'b0;
    checks++; if ({mem_req, mem_addr} !== {1'b1, 32'hFFFF_FFFC}) begin errors++; $display("FAIL wrap_fetch: req=%b addr=%h want 1/fffffffc", mem_req, mem_addr); end
    mem_rdy = 1'b1; mem_data = 32'h4444_4444;
    step();
    mem_rdy = 1'b0;
    checks++; if ({if_pc, if_inst} !== {32'hFFFF_FFFC, 32'h4444_4444}) begin errors++; $display("FAIL wrap_word: pc=%h inst=%h", if_pc, if_inst); end
    stall_command = STALL_NULL;
    step();
    checks++; if ({mem_req, mem_addr} !== {1'b1, 32'h0}) begin errors++; $display("FAIL wrap_advance: req=%b addr=%h want 1/0", mem_req, mem_addr); end
  endtask

  task automatic test_reset_mid_fetch();
    step();
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL pre_reset_req: req=%b want 1", mem_req); end
    rst = 1'b1; jp = 2'b10; jp_ex_target = 32'h500;
    mem_rdy = 1'b1; mem_data = 32'h6666_6666;
    step();
    jp = 2'b00;
    checks++; if ({mem_req, mem_addr, if_inst} !== {1'b0, 32'h0, 32'h0}) begin errors++; $display("FAIL reset_abandon: req=%b addr=%h inst=%h want 0/0/0", mem_req, mem_addr, if_inst); end
    rst = 1'b0; mem_data = 32'h5555_5555;
    step();
    mem_rdy = 1'b0;
    checks++; if ({mem_req, mem_addr, if_stall_req, if_inst} !== {1'b1, 32'h0, 1'b1, 32'h0}) begin errors++; $display("FAIL late_rdy: req=%b addr=%h stall=%b inst=%h", mem_req, mem_addr, if_stall_req, if_inst); end
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_stall();
    test_flush();
    test_jump_priority();
    test_wrap();
    test_reset_mid_fetch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
